shot_timer: RTL and testbench



---
 rtl/billiard_pkg.sv | 25 ++
 rtl/bcd2_down_counter.sv | 35 +++
 rtl/shot_timer.sv | 115 +++++++++++
 tb/tb_shot_timer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/billiard_pkg.sv
// Shared types for the billiard game timing blocks: shot-timer states,
// two-digit BCD values and a constant-friendly integer-to-BCD helper.
package billiard_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } shot_state_t;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  // Meant for elaboration-time constants; inputs above 99 are not expected.
  function automatic bcd2_t to_bcd2(input int unsigned val);
    bcd2_t res;
    res.tens = 4'((val / 10) % 10);
    res.ones = 4'(val % 10);
    return res;
  endfunction

endpackage

// File: rtl/bcd2_down_counter.sv
// Two-digit BCD down-counter with synchronous load; saturates at 00.
// Also exposes the next value so the parent can register flags derived from it.
module bcd2_down_counter
  import billiard_pkg::*;
(
  input  logic  clk,
  input  logic  load,
  input  bcd2_t load_val,
  input  logic  dec,
  output bcd2_t value,
  output bcd2_t value_next,
  output logic  zero_next
);

  always_comb begin
    value_next = value;
    if (load) begin
      value_next = load_val;
    end else if (dec && (value.tens != 4'd0 || value.ones != 4'd0)) begin
      if (value.ones == 4'd0) begin
        value_next.ones = 4'd9;
        value_next.tens = value.tens - 4'd1;
      end else begin
        value_next.ones = value.ones - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    value <= value_next;
  end

  assign zero_next = (value.tens == 4'd0) && (value.ones == 4'd1);

endmodule

// File: rtl/shot_timer.sv
// Per-turn shot clock: loads START_SECS, counts down in BCD on one_sec ticks.
// Define SHOT_TIMER_BLINK_EN to make warning blink (toggle per tick) in the window.
module shot_timer
  import billiard_pkg::*;
#(
  parameter int START_SECS = 30,
  parameter int WARN_SECS  = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       one_sec,
  input  logic       start,
  input  logic       hold,
  input  logic       clear,
  output logic [3:0] secs_tens,
  output logic [3:0] secs_ones,
  output logic       running,
  output logic       warning,
  output logic       expired,
  output logic       time_up
);

  localparam bcd2_t START_BCD = to_bcd2(START_SECS);
  localparam bcd2_t WARN_BCD  = to_bcd2(WARN_SECS);

  shot_state_t state, state_nxt;
  bcd2_t       count, count_nxt;
  logic        load, dec, zero_next, exp_nxt;
  logic        in_win, win_nxt;
  logic [7:0]  count_nxt_raw;

  // reset reuses the load path so the counter needs no reset of its own
  bcd2_down_counter u_count (
    .clk        (clk),
    .load       (load | reset),
    .load_val   (START_BCD),
    .dec        (dec),
    .value      (count),
    .value_next (count_nxt),
    .zero_next  (zero_next)
  );

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    dec       = 1'b0;
    exp_nxt   = 1'b0;
    if (clear) begin
      state_nxt = IDLE;
      load      = 1'b1;
    end else if (start) begin
      state_nxt = RUN;
      load      = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (hold) begin
            state_nxt = HOLD;
          end else if (one_sec) begin
            dec = 1'b1;
            if (zero_next) begin
              state_nxt = DONE;
              exp_nxt   = 1'b1;
            end
          end
        end
        HOLD: if (!hold) state_nxt = RUN;
        default: ;
      endcase
    end
  end

  // BCD digit ordering matches numeric ordering, so compare the raw bytes.
  assign count_nxt_raw = count_nxt;
  assign win_nxt = (state_nxt == RUN || state_nxt == HOLD) &&
                   (count_nxt_raw != 8'h00) && (count_nxt_raw <= WARN_BCD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      running <= 1'b0;
      expired <= 1'b0;
      time_up <= 1'b0;
      in_win  <= 1'b0;
    end else begin
      state   <= state_nxt;
      running <= (state_nxt == RUN);
      expired <= exp_nxt;
      time_up <= (state_nxt == DONE);
      in_win  <= win_nxt;
    end
  end

`ifdef SHOT_TIMER_BLINK_EN
  logic phase;

  always_ff @(posedge clk) begin
    if (reset || !win_nxt) begin
      phase <= 1'b0;
    end else if (!in_win) begin
      phase <= 1'b1;
    end else if (dec) begin
      phase <= ~phase;
    end
  end

  assign warning = phase;
`else
  assign warning = in_win;
`endif

  assign secs_tens = count.tens;
  assign secs_ones = count.ones;

endmodule

// File: tb/tb_shot_timer.sv
// Scoreboard bench for shot_timer: two instances (30/5 and 3/1) share stimulus;
// expectations are queued per cycle and checked by an independent monitor.
module tb_shot_timer;

  logic clk = 1'b0;
  logic reset, one_sec, start, hold, clear;
  logic [3:0] a_tens, a_ones, b_tens, b_ones;
  logic a_run, a_warn, a_exp, a_tu;
  logic b_run, b_warn, b_exp, b_tu;

  int cycle = 0;
  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string name;
    int    cyc;
    bit    which;
    int    cnt;
    bit    run;
    bit    warn;
    bit    expd;
    bit    tu;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  shot_timer #(.START_SECS(30), .WARN_SECS(5)) dut_a (
    .clk(clk), .reset(reset), .one_sec(one_sec), .start(start), .hold(hold),
    .clear(clear), .secs_tens(a_tens), .secs_ones(a_ones), .running(a_run),
    .warning(a_warn), .expired(a_exp), .time_up(a_tu)
  );

  shot_timer #(.START_SECS(3), .WARN_SECS(1)) dut_b (
    .clk(clk), .reset(reset), .one_sec(one_sec), .start(start), .hold(hold),
    .clear(clear), .secs_tens(b_tens), .secs_ones(b_ones), .running(b_run),
    .warning(b_warn), .expired(b_exp), .time_up(b_tu)
  );

  // Expected warning while RUN/HOLD at count c (window entered by counting down).
  function automatic bit wexp(input int c);
`ifdef SHOT_TIMER_BLINK_EN
    return (c >= 1 && c <= 5 && (c % 2) == 1);
`else
    return (c >= 1 && c <= 5);
`endif
  endfunction

  task automatic drive(input bit s, input bit h, input bit c, input bit t, input bit r);
    @(negedge clk);
    start = s; hold = h; clear = c; one_sec = t; reset = r;
  endtask

  task automatic push(input string nm, input bit w, input int cnt, input bit run,
                      input bit warn, input bit expd, input bit tu);
    exp_t e;
    e.name = nm; e.cyc = cycle + 1; e.which = w; e.cnt = cnt;
    e.run = run; e.warn = warn; e.expd = expd; e.tu = tu;
    sb.push_back(e);
  endtask

  // Monitor: compares every queued expectation due after the latest edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cycle) begin
      exp_t e;
      int act_cnt;
      bit r, w, x, u;
      e = sb.pop_front();
      vectors++;
      if (e.which) begin
        act_cnt = int'(b_tens) * 10 + int'(b_ones);
        r = b_run; w = b_warn; x = b_exp; u = b_tu;
      end else begin
        act_cnt = int'(a_tens) * 10 + int'(a_ones);
        r = a_run; w = a_warn; x = a_exp; u = a_tu;
      end
      if (e.cyc != cycle || act_cnt != e.cnt || r != e.run || w != e.warn ||
          x != e.expd || u != e.tu) begin
        miscompares++;
        $display("FAIL %s (cycle %0d): got cnt=%0d run=%0b warn=%0b exp=%0b tu=%0b, want cnt=%0d run=%0b warn=%0b exp=%0b tu=%0b",
                 e.name, cycle, act_cnt, r, w, x, u, e.cnt, e.run, e.warn, e.expd, e.tu);
      end
    end
  end

  initial begin
    int c;
    reset = 1'b1; one_sec = 1'b0; start = 1'b0; hold = 1'b0; clear = 1'b0;

    drive(0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 1);
    push("rst_a", 0, 30, 0, 0, 0, 0);
    push("rst_b", 1, 3, 0, 0, 0, 0);

    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 1, 0);
      push("idle_tick", 0, 30, 0, 0, 0, 0);
    end

    drive(1, 0, 0, 0, 0);
    push("start_a", 0, 30, 1, 0, 0, 0);
    push("start_b", 1, 3, 1, 0, 0, 0);
    c = 30;

    drive(0, 0, 0, 1, 0); c--;
    push("b_t1", 1, 2, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0); c--;
    push("b_t2", 1, 1, 1, 1, 0, 0);
    drive(0, 0, 0, 1, 0); c--;
    push("b_t3_zero", 1, 0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 0);
    push("b_exp_drop", 1, 0, 0, 0, 0, 1);
    push("a_idle_gap", 0, c, 1, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 1, 0); c--;
      push("b_stay_00", 1, 0, 0, 0, 0, 1);
    end

    while (c > 4) begin
      drive(0, 0, 0, 1, 0); c--;
      push("countdown", 0, c, 1, wexp(c), 0, 0);
    end

    drive(1, 0, 0, 1, 0); c = 30;
    push("restart_tick", 0, 30, 1, 0, 0, 0);
    while (c > 12) begin
      drive(0, 0, 0, 1, 0); c--;
      push("to_12", 0, c, 1, 0, 0, 0);
    end

    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 1, 0);
      push("hold", 0, 12, 0, 0, 0, 0);
    end
    drive(0, 0, 0, 0, 0);
    push("release", 0, 12, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0); c--;
    push("after_hold", 0, 11, 1, 0, 0, 0);

    while (c > 1) begin
      drive(0, 0, 0, 1, 0); c--;
      push("to_01", 0, c, 1, wexp(c), 0, 0);
    end
    drive(0, 0, 1, 1, 0); c = 30;
    push("clear_at_01", 0, 30, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    push("clear_no_exp", 0, 30, 0, 0, 0, 0);

    drive(1, 0, 0, 0, 0);
    push("start2", 0, 30, 1, 0, 0, 0);
    while (c > 0) begin
      drive(0, 0, 0, 1, 0); c--;
      push("run_out", 0, c, (c != 0), wexp(c), (c == 0), (c == 0));
    end
    drive(0, 0, 0, 1, 0);
    push("done_hold", 0, 0, 0, 0, 0, 1);

    drive(1, 0, 0, 1, 0); c = 30;
    push("done_restart", 0, 30, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0); c--;
    push("tick_29", 0, 29, 1, 0, 0, 0);
    drive(1, 0, 1, 0, 0); c = 30;
    push("clear_start", 0, 30, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    push("idle_discard", 0, 30, 0, 0, 0, 0);

    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    push("tick_28", 0, 28, 1, 0, 0, 0);
    drive(1, 0, 0, 1, 1);
    push("reset_mid", 0, 30, 0, 0, 0, 0);
    push("reset_mid_b", 1, 3, 0, 0, 0, 0);

    drive(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
